// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if: decoded key event bus from the PS/2 receiver to its consumer
interface ps2_keyboard_rx_if;
  logic [7:0] keycode;
  logic       extended;
  logic       new_key_strobe;
  logic       frame_error;
  modport master(output keycode, extended, new_key_strobe, frame_error);
  modport slave(input keycode, extended, new_key_strobe, frame_error);
endinterface

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 frame receiver with clock filter, watchdog and scan-code set 2 make/break decoder
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_keyboard_rx_if.master kb
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
  state_t state, state_n;
  logic [1:0] clk_s, dat_s;
  logic fclk, fclk_d, fe;
  logic [FW-1:0] fcnt;
  logic [3:0] bitcnt, bitcnt_n;
  logic [9:0] frame, frame_n;
  logic [WW-1:0] wd, wd_n;
  logic ext_pend, ext_n, brk_pend, brk_n;
  logic [7:0] key_n;
  logic xt_n, strobe_n, err_n;
  assign fe = fclk_d & ~fclk;
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s  <= 2'b11;
      dat_s  <= 2'b11;
      fclk   <= 1'b1;
      fclk_d <= 1'b1;
      fcnt   <= '0;
    end else begin
      clk_s  <= {clk_s[0], ps2_clk};
      dat_s  <= {dat_s[0], ps2_data};
      fcnt   <= (clk_s[1] == fclk || fcnt == FW'(FILTER_LEN - 1)) ? '0 : fcnt + 1'b1;
      fclk   <= (clk_s[1] != fclk && fcnt == FW'(FILTER_LEN - 1)) ? clk_s[1] : fclk;
      fclk_d <= fclk;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      bitcnt            <= '0;
      frame             <= '0;
      wd                <= '0;
      ext_pend          <= 1'b0;
      brk_pend          <= 1'b0;
      kb.keycode        <= '0;
      kb.extended       <= 1'b0;
      kb.new_key_strobe <= 1'b0;
      kb.frame_error    <= 1'b0;
    end else begin
      state             <= state_n;
      bitcnt            <= bitcnt_n;
      frame             <= frame_n;
      wd                <= wd_n;
      ext_pend          <= ext_n;
      brk_pend          <= brk_n;
      kb.keycode        <= key_n;
      kb.extended       <= xt_n;
      kb.new_key_strobe <= strobe_n;
      kb.frame_error    <= err_n;
    end
  end
  // frame holds {stop, parity, data[7:0]} once all ten bits have shifted in LSB-first
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    frame_n  = frame;
    wd_n     = '0;
    ext_n    = ext_pend;
    brk_n    = brk_pend;
    key_n    = kb.keycode;
    xt_n     = kb.extended;
    strobe_n = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: if (fe) begin
        err_n    = dat_s[1];
        state_n  = dat_s[1] ? IDLE : RECV;
        bitcnt_n = dat_s[1] ? 4'd0 : 4'd1;
      end
      RECV: if (fe) begin
        frame_n  = {dat_s[1], frame[9:1]};
        bitcnt_n = bitcnt + 4'd1;
        state_n  = (bitcnt == 4'd10) ? CHECK : RECV;
      end else if (wd == WW'(TIMEOUT_CYCLES)) begin
        err_n    = 1'b1;
        state_n  = IDLE;
        bitcnt_n = '0;
        ext_n    = 1'b0;
        brk_n    = 1'b0;
      end else begin
        wd_n = wd + 1'b1;
      end
      CHECK: begin
        state_n  = IDLE;
        bitcnt_n = '0;
        ext_n    = 1'b0;
        brk_n    = 1'b0;
        if (!frame[9] || !(^frame[8:0])) err_n = 1'b1;
        else if (frame[7:0] == 8'hE0) begin
          ext_n = 1'b1;
          brk_n = brk_pend;
        end else if (frame[7:0] == 8'hF0) begin
          brk_n = 1'b1;
          ext_n = ext_pend;
        end else if (frame[7:0] == 8'h00 || frame[7:0] == 8'hFF) err_n = 1'b1;
        else if (!brk_pend) begin
          key_n    = frame[7:0];
          xt_n     = ext_pend;
          strobe_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receives the PS/2 keyboard serial stream, validates each 11-bit frame and decodes scan-code set 2 make/break/extended sequences. For each key press it emits a one-cycle `new_key_strobe` with the make code on `keycode`. It is the producer side of the `keycode`/`new_key_strobe` interface consumed by the game state machine. It runs on the system clock `clk`; `ps2_clk` and `ps2_data` are asynchronous pad inputs.

## Interface
- `FILTER_LEN`, 8: consecutive `clk` cycles the synchronized `ps2_clk` must hold a new level before the filtered clock follows it.
- `TIMEOUT_CYCLES`, 10000: maximum `clk` cycles between filtered falling edges inside a frame (100 µs at 100 MHz).
- `clk` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high.
- `ps2_clk` input 1: keyboard clock, asynchronous.
- `ps2_data` input 1: keyboard data, asynchronous.
- `keycode` output 8: last accepted make code; held until the next accepted make code.
- `extended` output 1: high if the code on `keycode` was preceded by E0.
- `new_key_strobe` output 1: exactly one `clk` cycle high per accepted make code.
- `frame_error` output 1: one-cycle pulse on each discarded frame.

## Operation
- **Input conditioning**
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
  - Filtered clock `fclk` (reset 1) follows synchronized `ps2_clk` only after that value has been stable for `FILTER_LEN` cycles.
  - A falling edge (FE) is `fclk` 1→0.
  - Data is sampled from the synchronized `ps2_data` in the FE cycle.
- **Frame FSM**
  - IDLE: on FE, sample the start bit. If 1: `frame_error`, stay IDLE. If 0: go to RECV with `bitcnt`=1.
  - RECV: each FE stores bit `bitcnt`: 1–8 data LSB-first, 9 parity, 10 stop. After the bit-10 FE, go to CHECK.
  - CHECK (1 cycle): valid frame requires odd parity over data+parity and stop=1. Valid → pass the byte to the decoder. Invalid → `frame_error`, clear prefix flags. Always return to IDLE.
  - Watchdog: counts cycles since the last FE while in RECV. Reaching `TIMEOUT_CYCLES` → `frame_error`, go to IDLE, clear prefix flags.
- **Decoder**, on each valid byte:
  - E0: set `ext_pend`.
  - F0: set `brk_pend`.
  - 00 or FF (keyboard error/overrun): `frame_error`, clear both flags, no strobe.
  - Any other byte with `brk_pend`=1: break; no strobe; clear both flags.
  - Any other byte with `brk_pend`=0: make; `keycode`←byte, `extended`←`ext_pend`, pulse `new_key_strobe`, clear both flags.
- E0 and F0 are never presented on `keycode`.
- Typematic repeats (the same make code repeated) each produce a strobe.
- Reset values: `keycode`=00, `extended`=0, `new_key_strobe`=0, `frame_error`=0. Reset also sets the FSM to IDLE, `bitcnt`=0, both flags=0, `fclk`=1, filter and watchdog counters=0.

## Timing
- Latency: the bit-10 FE occurs in cycle N; CHECK is cycle N+1; `new_key_strobe`, `keycode` and `extended` update together in cycle N+2.
- `frame_error` is asserted in cycle N+2 for parity/stop/00/FF errors.
- For a bad start bit, `frame_error` is asserted in the cycle after the FE.
- For a timeout, `frame_error` is asserted in the cycle after the counter reaches `TIMEOUT_CYCLES`.
- `new_key_strobe` and `frame_error` are never high in the same cycle.
- Pulses on `ps2_clk` shorter than `FILTER_LEN` cycles are ignored.
- Reset asserted mid-frame: the partial frame is discarded silently (no `frame_error`); reception restarts at the next start bit.
- FE arriving in the CHECK cycle: cannot occur, because the filter enforces at least `FILTER_LEN` cycles between edges.

## Test plan
- Frame 0x1B (data 1,1,0,1,1,0,0,0, parity 1, stop 1) → `keycode`=1B, `extended`=0, one strobe at N+2.
- Frames E0, 75 → `keycode`=75, `extended`=1, one strobe. Then E0, F0, 75 → no strobe; `keycode` stays 75.
- Frames 76, F0, 76 → one strobe, `keycode`=76. Then 1B with parity forced to 0 → `frame_error` pulse, no strobe, `keycode` stays 76.
- Frames F0, then 1B with bad stop bit, then 1B valid → `frame_error` once, then a strobe with `keycode`=1B (the break flag was cleared by the error).
- Stop `ps2_clk` after 5 bits for `TIMEOUT_CYCLES` cycles → `frame_error` pulse. A following valid 4D frame → strobe, `keycode`=4D.
- 3-cycle glitches on `ps2_clk` during IDLE → no activity. Reset asserted after bit 4 of a frame → all outputs 0, no `frame_error`; the next valid 2D frame → strobe, `keycode`=2D.
